// File: rtl/dm_pkg.sv
// Shared encodings for the dm_master data-memory initiator: op codes, FSM states,
// byte-enable patterns and the address-decode helpers used by the top.
package dm_pkg;

   localparam logic [31:0] DM_ADDR_LIMIT = 32'h0000_2000;

   typedef enum logic [2:0] {
      OP_LW  = 3'b000,
      OP_LH  = 3'b001,
      OP_LHU = 3'b010,
      OP_LB  = 3'b011,
      OP_LBU = 3'b100,
      OP_SW  = 3'b101,
      OP_SH  = 3'b110,
      OP_SB  = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_ACCESS = 2'b01,
      S_RESP   = 2'b10,
      S_FAULT  = 2'b11
   } state_e;

   localparam logic [3:0] BE_WORD    = 4'b1111;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_B0      = 4'b0001;
   localparam logic [3:0] BE_B1      = 4'b0010;
   localparam logic [3:0] BE_B2      = 4'b0100;
   localparam logic [3:0] BE_B3      = 4'b1000;

   function automatic logic is_store(input op_e op);
      return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
   endfunction

   function automatic logic is_fault(input op_e op, input logic [31:0] addr,
                                     input logic [31:0] limit);
      logic l_misalign;
      case (op)
         OP_LW, OP_SW:         l_misalign = (addr[1:0] != 2'b00);
         OP_LH, OP_LHU, OP_SH: l_misalign = addr[0];
         default:              l_misalign = 1'b0;
      endcase
      return l_misalign || (addr >= limit);
   endfunction

   function automatic logic [3:0] byte_en(input op_e op, input logic [1:0] off);
      logic [3:0] l_be;
      case (op)
         OP_LW, OP_SW:         l_be = BE_WORD;
         OP_LH, OP_LHU, OP_SH: l_be = off[1] ? BE_HALF_HI : BE_HALF_LO;
         default: begin
            case (off)
               2'd0:    l_be = BE_B0;
               2'd1:    l_be = BE_B1;
               2'd2:    l_be = BE_B2;
               default: l_be = BE_B3;
            endcase
         end
      endcase
      return l_be;
   endfunction

   // Narrow stores are replicated into every lane; dm keeps only the enabled bytes.
   function automatic logic [31:0] store_data(input op_e op, input logic [31:0] wd);
      logic [31:0] l_wd;
      case (op)
         OP_SH:   l_wd = {2{wd[15:0]}};
         OP_SB:   l_wd = {4{wd[7:0]}};
         default: l_wd = wd;
      endcase
      return l_wd;
   endfunction

endpackage

// File: rtl/dm_master_load_ext.sv
// Selects the addressed byte/half of a dm read word and sign- or zero-extends it.
module dm_load_ext
   import dm_pkg::*;
(
   input  op_e         i_op,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_rd,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (i_off)
         2'd0:    w_byte = i_rd[7:0];
         2'd1:    w_byte = i_rd[15:8];
         2'd2:    w_byte = i_rd[23:16];
         default: w_byte = i_rd[31:24];
      endcase
      w_half = i_off[1] ? i_rd[31:16] : i_rd[15:0];
      case (i_op)
         OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
         OP_LBU:  o_data = {24'd0, w_byte};
         OP_LH:   o_data = {{16{w_half[15]}}, w_half};
         OP_LHU:  o_data = {16'd0, w_half};
         default: o_data = i_rd;
      endcase
   end

endmodule

// File: rtl/dm_master.sv
// MEM-stage initiator for the 2048x32 byte-enabled data memory: one load/store per
// request, alignment/range checking, lane-shifted stores and extended loads.
module dm_master
   import dm_pkg::*;
#(
   parameter logic [31:0] ADDR_LIMIT = DM_ADDR_LIMIT
)(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Req,
   input  logic [2:0]  Op,
   input  logic [31:0] Addr,
   input  logic [31:0] WData,
   output logic        Busy,
   output logic        Done,
   output logic [31:0] RData,
   output logic        AdEL,
   output logic        AdES,
   output logic [10:0] DmA,
   output logic [3:0]  DmBE,
   output logic [31:0] DmWD,
   output logic        DmWe,
   input  logic [31:0] DmRD
);

   state_e      r_state, w_next;
   op_e         r_op, w_op;
   logic [1:0]  r_off;
   logic [10:0] r_dma;
   logic [3:0]  r_dmbe;
   logic [31:0] r_dmwd, r_rdata, w_load;
   logic        w_accept, w_fault;

   assign w_op     = op_e'(Op);
   assign w_accept = (r_state == S_IDLE) && Req;
   assign w_fault  = is_fault(w_op, Addr, ADDR_LIMIT);

   dm_load_ext u_load_ext (
      .i_op   (r_op),
      .i_off  (r_off),
      .i_rd   (DmRD),
      .o_data (w_load)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // DmWe decodes straight from the state register so it cannot glitch.
   always_comb begin
      w_next = r_state;
      Busy   = 1'b1;
      Done   = 1'b0;
      AdEL   = 1'b0;
      AdES   = 1'b0;
      DmWe   = 1'b0;
      case (r_state)
         S_IDLE: begin
            Busy = 1'b0;
            if (Req) w_next = w_fault ? S_FAULT : S_ACCESS;
            else     w_next = S_IDLE;
         end
         S_ACCESS: begin
            DmWe   = is_store(r_op);
            w_next = S_RESP;
         end
         S_RESP: begin
            Done   = 1'b1;
            w_next = S_IDLE;
         end
         S_FAULT: begin
            Done   = 1'b1;
            AdEL   = ~is_store(r_op);
            AdES   = is_store(r_op);
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Faulting requests leave the dm-facing registers untouched.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_op    <= OP_LW;
         r_off   <= 2'd0;
         r_dma   <= 11'd0;
         r_dmbe  <= 4'd0;
         r_dmwd  <= 32'd0;
         r_rdata <= 32'd0;
      end else begin
         if (w_accept) begin
            r_op  <= w_op;
            r_off <= Addr[1:0];
            if (!w_fault) begin
               r_dma  <= Addr[12:2];
               r_dmbe <= byte_en(w_op, Addr[1:0]);
               r_dmwd <= store_data(w_op, WData);
            end
         end
         if ((r_state == S_ACCESS) && !is_store(r_op)) r_rdata <= w_load;
      end
   end

   assign DmA   = r_dma;
   assign DmBE  = r_dmbe;
   assign DmWD  = r_dmwd;
   assign RData = r_rdata;

endmodule

// File: tb/tb_dm_master.sv
// Randomized self-checking bench for dm_master with a byte-level reference memory
// and a per-cycle expected-output queue.
module tb_dm_master;

   localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                          LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

   logic        Clk = 1'b0, Reset = 1'b1, Req = 1'b0;
   logic [2:0]  Op = 3'd0;
   logic [31:0] Addr = 32'd0, WData = 32'd0;
   logic        Busy, Done, AdEL, AdES, DmWe;
   logic [31:0] RData, DmWD, DmRD;
   logic [10:0] DmA;
   logic [3:0]  DmBE;

   dm_master dut (
      .Clk(Clk), .Reset(Reset), .Req(Req), .Op(Op), .Addr(Addr), .WData(WData),
      .Busy(Busy), .Done(Done), .RData(RData), .AdEL(AdEL), .AdES(AdES),
      .DmA(DmA), .DmBE(DmBE), .DmWD(DmWD), .DmWe(DmWe), .DmRD(DmRD)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic        busy, done, adel, ades, we, chk_bus, chk_wd;
      logic [31:0] rdata;
      logic [10:0] dma;
      logic [3:0]  be;
      logic [31:0] wd;
   } rec_t;

   rec_t        expq[$];
   logic [31:0] model_rdata = 32'd0;
   bit          prev_busy = 1'b0;
   logic [7:0]  ref_mem [0:8191];
   logic [31:0] mem [0:2047];
   int          n_chk = 0, n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // dm model: combinational read, write at the clock edge; illegal BE zeroes the word.
   assign DmRD = mem[DmA];
   initial begin
      logic        we_s;
      logic [10:0] a_s;
      logic [3:0]  be_s;
      logic [31:0] wd_s;
      for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
      forever begin
         @(negedge Clk);
         we_s = DmWe; a_s = DmA; be_s = DmBE; wd_s = DmWD;
         @(posedge Clk);
         if (we_s === 1'b1 && !Reset) begin
            if (be_s inside {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000}) begin
               for (int b = 0; b < 4; b++)
                  if (be_s[b]) mem[a_s][8*b +: 8] = wd_s[8*b +: 8];
            end else begin
               mem[a_s] = 32'd0;
            end
         end
      end
   end

   // Reference: decide acceptance and queue the expected outputs for each following cycle.
   task automatic model_step(input logic req, input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] wd);
      int          size, a;
      bit          store, sgn, fault;
      logic [31:0] v, wrep;
      rec_t        r;
      if (req && !prev_busy) begin
         size  = (op == LW || op == SW) ? 4 : (op == LH || op == LHU || op == SH) ? 2 : 1;
         store = (op >= SW);
         sgn   = (op == LH || op == LB);
         fault = (addr >= 32'h2000) || ((addr % size) != 0);
         r = '0;
         r.busy = 1'b1;
         r.rdata = model_rdata;
         if (fault) begin
            r.done = 1'b1;
            r.adel = !store;
            r.ades = store;
            expq.push_back(r);
         end else begin
            a = int'(addr[12:0]);
            wrep = (size == 4) ? wd : (size == 2) ? {2{wd[15:0]}} : {4{wd[7:0]}};
            if (store) begin
               for (int i = 0; i < size; i++) ref_mem[a + i] = wd[8*i +: 8];
            end else begin
               v = 32'd0;
               for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[a + i];
               if (sgn && v[8*size - 1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
            end
            r.we = store;
            r.chk_bus = 1'b1;
            r.chk_wd = store;
            r.dma = addr[12:2];
            r.be = 4'(((1 << size) - 1) << addr[1:0]);
            r.wd = wrep;
            expq.push_back(r);
            if (!store) model_rdata = v;
            r = '0;
            r.busy = 1'b1;
            r.done = 1'b1;
            r.rdata = model_rdata;
            expq.push_back(r);
         end
      end
   endtask

   // Per-cycle compare against the queued expectations (idle when the queue is empty).
   initial begin
      rec_t e;
      forever begin
         @(negedge Clk);
         if (Reset) begin
            chk("rst_busy", Busy, 0); chk("rst_done", Done, 0);
            chk("rst_adel", AdEL, 0); chk("rst_ades", AdES, 0);
            chk("rst_we", DmWe, 0);   chk("rst_rdata", RData, 0);
            chk("rst_dma", DmA, 0);   chk("rst_dmbe", DmBE, 0);
            chk("rst_dmwd", DmWD, 0);
            prev_busy = 1'b0;
         end else begin
            if (expq.size() > 0) e = expq.pop_front();
            else begin
               e = '0;
               e.rdata = model_rdata;
            end
            chk("busy", Busy, e.busy);
            chk("done", Done, e.done);
            chk("adel", AdEL, e.adel);
            chk("ades", AdES, e.ades);
            chk("dmwe", DmWe, e.we);
            chk("rdata", RData, e.rdata);
            if (e.chk_bus) begin
               chk("dma", DmA, e.dma);
               chk("dmbe", DmBE, e.be);
            end
            if (e.chk_wd) chk("dmwd", DmWD, e.wd);
            prev_busy = e.busy;
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic we1, output logic [10:0] dma1,
                        output logic [3:0] be1, output logic adel, output logic ades);
      Req = 1'b1; Op = op; Addr = addr; WData = wd;
      @(posedge Clk);
      model_step(1'b1, op, addr, wd);
      @(negedge Clk);
      Req = 1'b0;
      we1 = DmWe; dma1 = DmA; be1 = DmBE; lat = 1;
      while (Done !== 1'b1 && lat < 8) begin
         @(negedge Clk);
         lat++;
      end
      adel = AdEL; ades = AdES;
      @(negedge Clk);
   endtask

   initial begin
      int          lat, nwe, sel;
      logic        we1, adel, ades;
      logic [10:0] dma1;
      logic [3:0]  be1;
      for (int i = 0; i < 8192; i++) ref_mem[i] = 8'd0;
      repeat (3) @(negedge Clk);
      #1 Reset = 1'b0;

      issue(SW, 32'h10, 32'hDEADBEEF, lat, we1, dma1, be1, adel, ades);
      chk("sw_we", we1, 1); chk("sw_dma", dma1, 11'd4); chk("sw_be", be1, 4'b1111);
      chk("sw_lat", lat, 2);
      issue(LW, 32'h10, 32'd0, lat, we1, dma1, be1, adel, ades);
      chk("lw_rdata", RData, 32'hDEADBEEF); chk("lw_lat", lat, 2); chk("lw_we", we1, 0);
      issue(SB, 32'h13, 32'h80, lat, we1, dma1, be1, adel, ades);
      chk("sb_be", be1, 4'b1000);
      issue(LB, 32'h13, 32'd0, lat, we1, dma1, be1, adel, ades);
      chk("lb_rdata", RData, 32'hFFFFFF80);
      issue(LBU, 32'h13, 32'd0, lat, we1, dma1, be1, adel, ades);
      chk("lbu_rdata", RData, 32'h00000080);
      issue(SH, 32'h12, 32'h1234ABCD, lat, we1, dma1, be1, adel, ades);
      chk("sh_be", be1, 4'b1100);
      issue(LH, 32'h12, 32'd0, lat, we1, dma1, be1, adel, ades);
      chk("lh_rdata", RData, 32'hFFFFABCD);
      issue(LHU, 32'h12, 32'd0, lat, we1, dma1, be1, adel, ades);
      chk("lhu_rdata", RData, 32'h0000ABCD);
      issue(LW, 32'h10, 32'd0, lat, we1, dma1, be1, adel, ades);
      chk("word_rdata", RData, 32'hABCDBEEF);
      issue(LW, 32'h11, 32'd0, lat, we1, dma1, be1, adel, ades);
      chk("adel_flag", adel, 1); chk("adel_lat", lat, 1); chk("adel_we", we1, 0);
      issue(SH, 32'h2000, 32'h5555, lat, we1, dma1, be1, adel, ades);
      chk("ades_flag", ades, 1); chk("ades_adel", adel, 0); chk("ades_rdata", RData, 32'hABCDBEEF);

      // Req held high: only idle-cycle requests are taken.
      Req = 1'b1; Op = SW; Addr = 32'h20; WData = 32'hCAFEF00D; nwe = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge Clk);
         model_step(Req, Op, Addr, WData);
         @(negedge Clk);
         if (DmWe === 1'b1) nwe++;
      end
      Req = 1'b0;
      chk("held_we_count", nwe, 2);
      @(negedge Clk);

      // Reset during the ACCESS cycle of a store must suppress the write.
      Req = 1'b1; Op = SW; Addr = 32'h10; WData = 32'h11111111;
      @(posedge Clk);
      #2;
      chk("rst_pre_we", DmWe, 1);
      Req = 1'b0;
      Reset = 1'b1;
      #1;
      chk("rst_we_drop", DmWe, 0);
      chk("rst_mid_busy", Busy, 0);
      expq.delete();
      model_rdata = 32'd0;
      repeat (2) @(negedge Clk);
      #1 Reset = 1'b0;
      issue(LW, 32'h10, 32'd0, lat, we1, dma1, be1, adel, ades);
      chk("rst_word_kept", RData, 32'hABCDBEEF);

      for (int n = 0; n < 400; n++) begin
         sel   = $urandom_range(0, 9);
         Req   = ($urandom_range(0, 3) != 0);
         Op    = 3'($urandom_range(0, 7));
         WData = $urandom;
         case (sel)
            0:       Addr = $urandom;
            1:       Addr = 32'h2000 + 32'($urandom_range(0, 15));
            2:       Addr = 32'h1FF0 + 32'($urandom_range(0, 15));
            default: Addr = 32'($urandom_range(0, 63));
         endcase
         @(posedge Clk);
         model_step(Req, Op, Addr, WData);
         @(negedge Clk);
      end
      Req = 1'b0;
      repeat (4) @(negedge Clk);
      chk("queue_drained", expq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
